// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: writeback request queue handshake and register-file write port
interface regfile_writeback_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_word;
  logic [5:0]  in_d;
  logic [15:0] in_data;
  logic        rf_write;
  logic        rf_write_word;
  logic [5:0]  rf_d;
  logic [15:0] rf_Rd;
  modport master (
    output in_valid, in_word, in_d, in_data,
    input  in_ready, rf_write, rf_write_word, rf_d, rf_Rd
  );
  modport slave (
    input  in_valid, in_word, in_d, in_data,
    output in_ready, rf_write, rf_write_word, rf_d, rf_Rd
  );
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: queued register-file write initiator with odd-word splitting and hazard stall
module regfile_writeback #(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  regfile_writeback_if.slave  bus,
  input  logic [5:0]          hz_a,
  input  logic                hz_a_word,
  input  logic [5:0]          hz_b,
  output logic                hz_stall,
  output logic                idle
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {ISSUE, SPLIT_HI} state_t;
  state_t          state_q;
  logic [DEPTH-1:0] word_q;
  logic [5:0]      d_q [DEPTH];
  logic [15:0]     data_q [DEPTH];
  logic [AW-1:0]   rd_q, wr_q, idx;
  logic [AW:0]     cnt_q, cnt_d;
  logic [5:0]      last_d_q, h_d, cur_d;
  logic [15:0]     last_rd_q, h_data, cur_rd;
  logic            split, pres, unal, cur_word, push, pop;
  logic [63:0]     pend, rmask;
  assign split    = state_q == SPLIT_HI;
  assign h_d      = d_q[rd_q];
  assign h_data   = data_q[rd_q];
  assign pres     = reset && (split || cnt_q != '0);
  assign unal     = word_q[rd_q] && h_d[0];
  assign cur_word = !split && word_q[rd_q] && !h_d[0];
  assign cur_d    = split ? h_d + 6'd1 : h_d;
  assign cur_rd   = cur_word ? h_data : {8'h00, split ? h_data[15:8] : h_data[7:0]};
  assign push     = bus.in_valid && bus.in_ready;
  assign pop      = pres && (split || !unal);
  assign cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  assign bus.in_ready      = reset && cnt_q != (AW+1)'(DEPTH);
  assign bus.rf_write      = pres;
  assign bus.rf_write_word = pres && cur_word;
  assign bus.rf_d          = pres ? cur_d : last_d_q;
  assign bus.rf_Rd         = pres ? cur_rd : last_rd_q;
  assign idle     = !reset || (cnt_q == '0 && !split);
  assign rmask    = (64'd1 << hz_a) | (hz_a_word ? 64'd1 << (hz_a + 6'd1) : 64'd0) | (64'd1 << hz_b);
  assign hz_stall = reset && |(pend & rmask);
  // Bytes still owed to the register file; a split head's low byte is already done, and the bytes on rf_* now are forwarded
  always_comb begin
    pend = '0;
    idx = rd_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_q + AW'(k);
      if ((AW+1)'(k) < cnt_q) begin
        if (!(k == 0 && split)) pend[d_q[idx]] = 1'b1;
        if (word_q[idx]) pend[d_q[idx] + 6'd1] = 1'b1;
      end
    end
    if (pres) pend[cur_d] = 1'b0;
    if (pres && cur_word) pend[cur_d + 6'd1] = 1'b0;
  end
  // Queue pointers, occupancy and issue/split sequencing
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ISSUE;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      if (push) begin
        word_q[wr_q] <= bus.in_word;
        d_q[wr_q]    <= bus.in_d;
        data_q[wr_q] <= bus.in_data;
        wr_q         <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q   <= cnt_d;
      state_q <= (pres && !split && unal) ? SPLIT_HI : ISSUE;
    end
  end
  // rf_d/rf_Rd keep the last presented write while the port is quiet
  always_ff @(posedge clk) begin
    if (pres) begin
      last_d_q  <= cur_d;
      last_rd_q <= cur_rd;
    end
  end
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed plus random stimulus against a queue-based reference model
module tb_regfile_writeback;
  localparam int DEPTH = 2;
  typedef struct {logic w; logic [5:0] d; logic [15:0] data;} req_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] hz_a = '0, hz_b = '0;
  logic hz_a_word = 1'b0;
  logic hz_stall, idle;
  int tests = 0, fails = 0;
  req_t q[$];
  bit half = 0, last_ok = 0, acc = 0;
  logic [5:0] last_d = '0;
  logic [15:0] last_rd = '0;
  regfile_writeback_if bus();
  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus), .hz_a(hz_a), .hz_a_word(hz_a_word),
    .hz_b(hz_b), .hz_stall(hz_stall), .idle(idle)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // One clock cycle: drive a request, compare all outputs with the model, then advance the model across the edge
  task automatic step(input logic v, input logic w, input logic [5:0] d, input logic [15:0] dat);
    bit pend[64];
    bit ew, eww, rdy, stall;
    logic [5:0] ed;
    logic [15:0] er;
    bus.in_valid = v; bus.in_word = w; bus.in_d = d; bus.in_data = dat;
    #1;
    ew = reset && (half || q.size() > 0);
    eww = 0; ed = last_d; er = last_rd;
    if (ew) begin
      if (half) begin
        ed = 6'((int'(q[0].d) + 1) % 64); er = {8'h00, q[0].data[15:8]};
      end else if (q[0].w && q[0].d % 2 == 0) begin
        eww = 1; ed = q[0].d; er = q[0].data;
      end else begin
        ed = q[0].d; er = {8'h00, q[0].data[7:0]};
      end
    end
    foreach (pend[i]) pend[i] = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (!(i == 0 && half)) pend[q[i].d] = 1;
      if (q[i].w) pend[(int'(q[i].d) + 1) % 64] = 1;
    end
    if (ew) pend[ed] = 0;
    if (eww) pend[(int'(ed) + 1) % 64] = 0;
    stall = reset && (pend[hz_a] || (hz_a_word && pend[(int'(hz_a) + 1) % 64]) || pend[hz_b]);
    rdy = reset && q.size() < DEPTH;
    chk("rf_write", 16'(bus.rf_write), 16'(ew));
    chk("in_ready", 16'(bus.in_ready), 16'(rdy));
    chk("idle", 16'(idle), 16'(!reset || (q.size() == 0 && !half)));
    chk("hz_stall", 16'(hz_stall), 16'(stall));
    if (reset) chk("rf_write_word", 16'(bus.rf_write_word), 16'(eww));
    if (reset && (ew || last_ok)) begin
      chk("rf_d", 16'(bus.rf_d), 16'(ed));
      chk("rf_Rd", bus.rf_Rd, er);
    end
    acc = rdy && v;
    if (!reset) begin
      q.delete();
      half = 0;
    end else begin
      if (ew) begin last_d = ed; last_rd = er; last_ok = 1; end
      if (half) begin
        void'(q.pop_front()); half = 0;
      end else if (q.size() > 0) begin
        if (q[0].w && q[0].d % 2 == 1) half = 1;
        else void'(q.pop_front());
      end
      if (acc) q.push_back('{w, d, dat});
    end
    @(posedge clk); #1;
  endtask
  task automatic idle_step();
    step(1'b0, 1'b0, 6'd0, 16'h0);
  endtask
  task automatic push(input logic w, input logic [5:0] d, input logic [15:0] dat);
    int n = 0;
    do begin
      step(1'b1, w, d, dat);
      n++;
    end while (!acc && n < 10);
  endtask
  function automatic logic [5:0] near();
    if ($urandom_range(0, 3) == 0) return 6'($urandom_range(0, 63));
    return $urandom_range(0, 1) ? 6'($urandom_range(0, 5)) : 6'($urandom_range(58, 63));
  endfunction
  initial begin
    bus.in_valid = 0; bus.in_word = 0; bus.in_d = '0; bus.in_data = '0;
    @(posedge clk); #1;
    idle_step(); idle_step();
    reset = 1;
    idle_step();
    push(1'b0, 6'd5, 16'h12AB); idle_step(); idle_step();
    push(1'b1, 6'd24, 16'hBEEF); push(1'b1, 6'd27, 16'h1234); repeat (4) idle_step();
    push(1'b1, 6'd27, 16'h5678); push(1'b0, 6'd1, 16'h0011); push(1'b0, 6'd2, 16'h0022);
    push(1'b0, 6'd3, 16'h0033); repeat (6) idle_step();
    hz_a = 6'd31; hz_a_word = 0; hz_b = 6'd10;
    push(1'b1, 6'd27, 16'h0102); push(1'b1, 6'd30, 16'hCAFE); repeat (5) idle_step();
    hz_a = 6'd0; hz_b = 6'd0;
    push(1'b1, 6'd63, 16'hA5C3); idle_step();
    reset = 0; idle_step();
    reset = 1; repeat (3) idle_step();
    push(1'b1, 6'd63, 16'hA5C3); repeat (4) idle_step();
    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 49) != 0);
      hz_a = near(); hz_b = near(); hz_a_word = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), near(), 16'($urandom));
    end
    reset = 1;
    repeat (6) idle_step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
